// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
// Writeback buffer sitting in front of a 16-entry, two-write-port register
// file. Results from the ALU channel (A) and the load channel (M) are queued
// in arrival order (A before M within a cycle). Up to two of the oldest
// entries are drained per cycle onto write ports Rd (oldest) and Rs
// (second oldest). A pending-write lookup lets decode see whether a register
// still has an undrained result.
//
// Ports
//   i_Clock, i_Reset_n          clock, asynchronous active-low reset
//   i_A_Valid/Addr/Data         channel A result, o_A_Ready handshake
//   i_M_Valid/Addr/Data         channel M result, o_M_Ready handshake
//   i_Drain_En                  permit draining this cycle
//   o_Rd_Wen/Addr/Data          register file write port Rd (oldest entry)
//   o_Rs_Wen/Addr/Data          register file write port Rs (second oldest)
//   i_Pend_Addr, o_Pend_Hit     pending-write lookup
//   o_Count                     queue occupancy
//   o_Addr_Err                  sticky: an out-of-range address was dropped
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 7,
  parameter int NREG  = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     i_A_Valid,
  input  logic [AW-1:0]            i_A_Addr,
  input  logic [DW-1:0]            i_A_Data,
  output logic                     o_A_Ready,
  input  logic                     i_M_Valid,
  input  logic [AW-1:0]            i_M_Addr,
  input  logic [DW-1:0]            i_M_Data,
  output logic                     o_M_Ready,
  input  logic                     i_Drain_En,
  output logic                     o_Rd_Wen,
  output logic [AW-1:0]            o_Rd_Addr,
  output logic [DW-1:0]            o_Rd_Data,
  output logic                     o_Rs_Wen,
  output logic [AW-1:0]            o_Rs_Addr,
  output logic [DW-1:0]            o_Rs_Data,
  input  logic [AW-1:0]            i_Pend_Addr,
  output logic                     o_Pend_Hit,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Addr_Err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_addr_err;

  logic [CW-1:0] w_free;
  logic          w_a_ready;
  logic          w_m_ready;
  logic          w_a_acc;
  logic          w_m_acc;
  logic          w_a_push;
  logic          w_m_push;
  logic [PW-1:0] w_m_idx;
  logic [PW-1:0] w_rs_idx;
  logic          w_rd_wen;
  logic          w_rs_wen;
  logic          w_pend_hit;

  // Free space is judged on registered occupancy only, so a pop in the same
  // cycle never opens a slot for an incoming result.
  assign w_free    = CW'(DEPTH) - r_count;
  assign w_a_ready = (w_free >= CW'(1));
  assign w_m_ready = i_A_Valid ? (w_free >= CW'(2)) : (w_free >= CW'(1));

  assign w_a_acc  = i_A_Valid & w_a_ready;
  assign w_m_acc  = i_M_Valid & w_m_ready;
  // Out-of-range destinations complete their handshake but are dropped.
  assign w_a_push = w_a_acc & (i_A_Addr < AW'(NREG));
  assign w_m_push = w_m_acc & (i_M_Addr < AW'(NREG));

  // M lands behind A when both are enqueued in the same cycle.
  assign w_m_idx  = r_wr_ptr + PW'(w_a_push);
  assign w_rs_idx = r_rd_ptr + PW'(1);

  assign w_rd_wen = i_Drain_En & (r_count >= CW'(1));
  assign w_rs_wen = i_Drain_En & (r_count >= CW'(2));

  // Pending lookup: an entry is live when its distance from the read pointer
  // is below the occupancy; entries being popped this cycle still count.
  always_comb begin
    w_pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend_hit = w_pend_hit |
                   (({1'b0, PW'(i) - r_rd_ptr} < r_count) &&
                    (r_addr[i] == i_Pend_Addr));
    end
  end

  // Entry storage: write accepted, in-range results into free slots.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= {AW{1'b0}};
        r_data[i] <= {DW{1'b0}};
      end
    end else begin
      if (w_a_push) begin
        r_addr[r_wr_ptr] <= i_A_Addr;
        r_data[r_wr_ptr] <= i_A_Data;
      end
      if (w_m_push) begin
        r_addr[w_m_idx] <= i_M_Addr;
        r_data[w_m_idx] <= i_M_Data;
      end
    end
  end

  // Pointers, occupancy and the sticky address-error flag.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_addr_err <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_a_push) + PW'(w_m_push);
      r_rd_ptr <= r_rd_ptr + PW'(w_rd_wen) + PW'(w_rs_wen);
      r_count  <= r_count + CW'(w_a_push) + CW'(w_m_push)
                          - CW'(w_rd_wen) - CW'(w_rs_wen);
      if ((w_a_acc && !w_a_push) || (w_m_acc && !w_m_push)) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign o_A_Ready  = w_a_ready;
  assign o_M_Ready  = w_m_ready;
  assign o_Rd_Wen   = w_rd_wen;
  assign o_Rd_Addr  = r_addr[r_rd_ptr];
  assign o_Rd_Data  = r_data[r_rd_ptr];
  assign o_Rs_Wen   = w_rs_wen;
  assign o_Rs_Addr  = r_addr[w_rs_idx];
  assign o_Rs_Data  = r_data[w_rs_idx];
  assign o_Pend_Hit = w_pend_hit;
  assign o_Count    = r_count;
  assign o_Addr_Err = r_addr_err;

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 7;
  localparam int NREG  = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, m_valid, drain;
  logic [AW-1:0] a_addr, m_addr, pend_addr;
  logic [DW-1:0] a_data, m_data;
  logic          a_ready, m_ready, rd_wen, rs_wen, pend_hit, addr_err;
  logic [AW-1:0] rd_addr, rs_addr;
  logic [DW-1:0] rd_data, rs_data;
  logic [2:0]    count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: ordered queue of live entries, expected register file.
  ent_t        q[$];
  logic        err_exp = 1'b0;
  logic [DW-1:0] rf_exp [NREG] = '{default: 16'h0000};
  // Register file image built from what the DUT actually writes.
  logic [DW-1:0] rf_obs [NREG] = '{default: 16'h0000};

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .NREG(NREG)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .i_A_Valid(a_valid), .i_A_Addr(a_addr), .i_A_Data(a_data), .o_A_Ready(a_ready),
    .i_M_Valid(m_valid), .i_M_Addr(m_addr), .i_M_Data(m_data), .o_M_Ready(m_ready),
    .i_Drain_En(drain),
    .o_Rd_Wen(rd_wen), .o_Rd_Addr(rd_addr), .o_Rd_Data(rd_data),
    .o_Rs_Wen(rs_wen), .o_Rs_Addr(rs_addr), .o_Rs_Data(rs_data),
    .i_Pend_Addr(pend_addr), .o_Pend_Hit(pend_hit),
    .o_Count(count), .o_Addr_Err(addr_err)
  );

  // Register file: Rs wins when both ports target the same register.
  always @(posedge clk) begin
    if (rd_wen && rd_addr < AW'(NREG)) rf_obs[rd_addr[3:0]] <= rd_data;
    if (rs_wen && rs_addr < AW'(NREG)) rf_obs[rs_addr[3:0]] <= rs_data;
    if (rs_wen && rs_addr < AW'(NREG) && !(rd_wen && rd_addr == rs_addr))
      rf_obs[rs_addr[3:0]] <= rs_data;
  end

  task automatic model_update();
    int free, n;
    bit ar, mr;
    if (!rst_n) return;
    free = DEPTH - q.size();
    ar = (free >= 1);
    mr = a_valid ? (free >= 2) : (free >= 1);
    n = drain ? ((q.size() >= 2) ? 2 : q.size()) : 0;
    for (int k = 0; k < n; k++) rf_exp[q[k].addr[3:0]] = q[k].data;
    repeat (n) void'(q.pop_front());
    if (a_valid && ar) begin
      if (a_addr < AW'(NREG)) q.push_back('{addr: a_addr, data: a_data});
      else err_exp = 1'b1;
    end
    if (m_valid && mr) begin
      if (m_addr < AW'(NREG)) q.push_back('{addr: m_addr, data: m_data});
      else err_exp = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; m_valid = 1'b0; drain = 1'b0;
    a_addr = '0; m_addr = '0; a_data = '0; m_data = '0; pend_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    q.delete(); err_exp = 1'b0;
    #1;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_chk++; if ({rd_wen, rs_wen, pend_hit, addr_err} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags: got rd_wen=%b rs_wen=%b hit=%b err=%b expected all 0", rd_wen, rs_wen, pend_hit, addr_err); end
    n_chk++; if ({rd_addr, rd_data, rs_addr, rs_data} !== 46'h0) begin n_fail++;
      $display("FAIL reset_ports: got rd=%0h/%0h rs=%0h/%0h expected 0", rd_addr, rd_data, rs_addr, rs_data); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if ({a_ready, m_ready} !== 2'b11) begin n_fail++;
      $display("FAIL reset_ready: got a=%b m=%b expected 1 1", a_ready, m_ready); end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_addr = 7'd3; a_data = 16'h1234; drain = 1'b1;
    tick();
    a_valid = 1'b0;
    #1;
    n_chk++; if ({rd_wen, rd_addr, rd_data, rs_wen} !== {1'b1, 7'd3, 16'h1234, 1'b0}) begin n_fail++;
      $display("FAIL single_out: got rd_wen=%b rd=%0d/%0h rs_wen=%b expected 1 3/1234 0", rd_wen, rd_addr, rd_data, rs_wen); end
    tick();
    #1;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d expected 0", count); end
    n_chk++; if (rf_obs[3] !== 16'h1234) begin n_fail++; $display("FAIL single_r3: got %0h expected 1234", rf_obs[3]); end
  endtask

  task automatic test_same_dest();
    a_valid = 1'b1; a_addr = 7'd5; a_data = 16'hAAAA;
    m_valid = 1'b1; m_addr = 7'd5; m_data = 16'hBBBB; drain = 1'b1;
    tick();
    a_valid = 1'b0; m_valid = 1'b0;
    #1;
    n_chk++; if ({rd_wen, rd_addr, rd_data, rs_wen, rs_addr, rs_data} !==
                 {1'b1, 7'd5, 16'hAAAA, 1'b1, 7'd5, 16'hBBBB}) begin n_fail++;
      $display("FAIL same_dest_out: got rd=%b/%0d/%0h rs=%b/%0d/%0h expected 1/5/aaaa 1/5/bbbb",
               rd_wen, rd_addr, rd_data, rs_wen, rs_addr, rs_data); end
    tick();
    #1;
    n_chk++; if (rf_obs[5] !== 16'hBBBB) begin n_fail++; $display("FAIL same_dest_r5: got %0h expected bbbb", rf_obs[5]); end
  endtask

  task automatic test_backpressure();
    drain = 1'b0;
    a_valid = 1'b1; a_addr = 7'd1; a_data = 16'h1111;
    m_valid = 1'b1; m_addr = 7'd2; m_data = 16'h2222;
    #1;
    n_chk++; if ({a_ready, m_ready} !== 2'b11) begin n_fail++; $display("FAIL bp_ready0: got %b%b expected 11", a_ready, m_ready); end
    tick();
    a_addr = 7'd3; a_data = 16'h3333; m_addr = 7'd4; m_data = 16'h4444;
    #1;
    n_chk++; if ({count, m_ready} !== {3'd2, 1'b1}) begin n_fail++;
      $display("FAIL bp_count2: got count=%0d m_ready=%b expected 2 1", count, m_ready); end
    tick();
    #1;
    n_chk++; if ({count, a_ready, m_ready} !== {3'd4, 2'b00}) begin n_fail++;
      $display("FAIL bp_full: got count=%0d a=%b m=%b expected 4 0 0", count, a_ready, m_ready); end
    tick();
    #1;
    n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_hold: got %0d expected 4", count); end
  endtask

  task automatic test_drain_order();
    a_addr = 7'd5; a_data = 16'h5555; m_addr = 7'd6; m_data = 16'h6666; drain = 1'b1;
    #1;
    n_chk++; if ({rd_addr, rd_data, rs_addr, rs_data, a_ready} !== {7'd1, 16'h1111, 7'd2, 16'h2222, 1'b0}) begin n_fail++;
      $display("FAIL drain_first: got rd=%0d/%0h rs=%0d/%0h a_ready=%b expected 1/1111 2/2222 0",
               rd_addr, rd_data, rs_addr, rs_data, a_ready); end
    tick();
    #1;
    n_chk++; if ({count, rd_addr, rd_data, rs_addr, rs_data} !== {3'd2, 7'd3, 16'h3333, 7'd4, 16'h4444}) begin n_fail++;
      $display("FAIL drain_second: got count=%0d rd=%0d/%0h rs=%0d/%0h expected 2 3/3333 4/4444",
               count, rd_addr, rd_data, rs_addr, rs_data); end
    tick();
    a_valid = 1'b0; m_valid = 1'b0;
    #1;
    n_chk++; if ({count, rd_addr, rd_data, rs_addr, rs_data} !== {3'd2, 7'd5, 16'h5555, 7'd6, 16'h6666}) begin n_fail++;
      $display("FAIL drain_wrap: got count=%0d rd=%0d/%0h rs=%0d/%0h expected 2 5/5555 6/6666",
               count, rd_addr, rd_data, rs_addr, rs_data); end
    tick();
    drain = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_valid = 1'b1; a_addr = 7'(10 + k); a_data = 16'(16'hC000 + k);
      tick();
    end
    a_valid = 1'b1; m_valid = 1'b1; a_addr = 7'd13; m_addr = 7'd14;
    #1;
    n_chk++; if ({count, a_ready, m_ready} !== {3'd3, 2'b10}) begin n_fail++;
      $display("FAIL count3_ready: got count=%0d a=%b m=%b expected 3 1 0", count, a_ready, m_ready); end
    tick();
    a_valid = 1'b0; m_valid = 1'b0; drain = 1'b1;
    tick(); tick();
    #1;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got %0d expected 0", count); end
  endtask

  task automatic test_addr_err();
    drain = 1'b1; a_valid = 1'b1; a_addr = 7'd20; a_data = 16'hDEAD;
    #1;
    n_chk++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready: got %b expected 1", a_ready); end
    tick();
    a_valid = 1'b0;
    #1;
    n_chk++; if ({addr_err, count, rd_wen} !== {1'b1, 3'd0, 1'b0}) begin n_fail++;
      $display("FAIL err_set: got err=%b count=%0d rd_wen=%b expected 1 0 0", addr_err, count, rd_wen); end
    tick(); tick(); tick();
    #1;
    n_chk++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", addr_err); end
  endtask

  task automatic test_pend_and_reset();
    drain = 1'b0; a_valid = 1'b1; a_addr = 7'd7; a_data = 16'h7777;
    tick();
    a_valid = 1'b0; pend_addr = 7'd7;
    #1;
    n_chk++; if (pend_hit !== 1'b1) begin n_fail++; $display("FAIL pend_hit7: got %b expected 1", pend_hit); end
    pend_addr = 7'd8;
    #1;
    n_chk++; if (pend_hit !== 1'b0) begin n_fail++; $display("FAIL pend_miss8: got %b expected 0", pend_hit); end
    pend_addr = 7'd7; drain = 1'b1;
    #1;
    n_chk++; if ({pend_hit, rd_wen} !== 2'b11) begin n_fail++;
      $display("FAIL pend_popping: got hit=%b rd_wen=%b expected 1 1", pend_hit, rd_wen); end
    tick();
    #1;
    n_chk++; if (pend_hit !== 1'b0) begin n_fail++; $display("FAIL pend_drained: got %b expected 0", pend_hit); end
    drain = 1'b0;
    a_valid = 1'b1; a_addr = 7'd1; m_valid = 1'b1; m_addr = 7'd7;
    tick();
    m_valid = 1'b0; a_addr = 7'd2;
    tick();
    a_valid = 1'b0;
    #1;
    n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL pend_fill3: got %0d expected 3", count); end
    rst_n = 1'b0; drain = 1'b1;
    q.delete(); err_exp = 1'b0;
    #1;
    n_chk++; if ({count, rd_wen, rs_wen, pend_hit, addr_err} !== {3'd0, 4'b0000}) begin n_fail++;
      $display("FAIL midreset: got count=%0d rd=%b rs=%b hit=%b err=%b expected 0 0 0 0 0",
               count, rd_wen, rs_wen, pend_hit, addr_err); end
    tick();
    #1;
    n_chk++; if ({count, rd_wen} !== {3'd0, 1'b0}) begin n_fail++;
      $display("FAIL midreset_hold: got count=%0d rd_wen=%b expected 0 0", count, rd_wen); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_random();
    int free;
    bit e_ar, e_mr, e_hit, e_rd, e_rs;
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_valid = 1'($urandom_range(0, 1));
      m_valid = 1'($urandom_range(0, 1));
      a_addr  = ($urandom_range(0, 11) == 0) ? 7'($urandom_range(16, 127)) : 7'($urandom_range(0, 15));
      m_addr  = ($urandom_range(0, 11) == 0) ? 7'($urandom_range(16, 127)) : 7'($urandom_range(0, 15));
      a_data  = 16'($urandom);
      m_data  = 16'($urandom);
      drain   = ($urandom_range(0, 2) != 0);
      pend_addr = 7'($urandom_range(0, 15));
      #1;
      free = DEPTH - q.size();
      e_ar = (free >= 1);
      e_mr = a_valid ? (free >= 2) : (free >= 1);
      e_rd = drain && q.size() >= 1;
      e_rs = drain && q.size() >= 2;
      e_hit = 1'b0;
      foreach (q[k]) if (q[k].addr == pend_addr) e_hit = 1'b1;
      n_chk++; if ({a_ready, m_ready} !== {e_ar, e_mr}) begin n_fail++;
        $display("FAIL rand_ready c%0d: got %b%b expected %b%b", cyc, a_ready, m_ready, e_ar, e_mr); end
      n_chk++; if (count !== 3'(q.size())) begin n_fail++;
        $display("FAIL rand_count c%0d: got %0d expected %0d", cyc, count, q.size()); end
      n_chk++; if ({rd_wen, rs_wen, pend_hit, addr_err} !== {e_rd, e_rs, e_hit, err_exp}) begin n_fail++;
        $display("FAIL rand_flags c%0d: got rd=%b rs=%b hit=%b err=%b expected %b %b %b %b",
                 cyc, rd_wen, rs_wen, pend_hit, addr_err, e_rd, e_rs, e_hit, err_exp); end
      if (q.size() >= 1 && e_rd) begin
        n_chk++; if ({rd_addr, rd_data} !== q[0]) begin n_fail++;
          $display("FAIL rand_rd c%0d: got %0d/%0h expected %0d/%0h", cyc, rd_addr, rd_data, q[0].addr, q[0].data); end
      end
      if (q.size() >= 2 && e_rs) begin
        n_chk++; if ({rs_addr, rs_data} !== q[1]) begin n_fail++;
          $display("FAIL rand_rs c%0d: got %0d/%0h expected %0d/%0h", cyc, rs_addr, rs_data, q[1].addr, q[1].data); end
      end
      tick();
    end
    idle_inputs();
    drain = 1'b1;
    tick(); tick(); tick();
    for (int r = 0; r < NREG; r++) begin
      n_chk++; if (rf_obs[r] !== rf_exp[r]) begin n_fail++;
        $display("FAIL rand_regfile r%0d: got %0h expected %0h", r, rf_obs[r], rf_exp[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_dest();
    test_backpressure();
    test_drain_order();
    test_addr_err();
    test_pend_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
Writeback buffer directly upstream of the 16-entry register file. Accepts results from two producers (ALU channel A, load/memory channel M), queues them in order in a small FIFO, and drains up to two entries per cycle onto the register file's two write ports (Rd, Rs). Also provides a pending-write lookup so decode can stall on a register with an undrained result.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
DW, 16, data width
AW, 7, register address width
NREG, 16, implemented registers; legal addresses 0..NREG-1

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  asynchronous active-low reset
A_Valid  in  1  channel A result valid
A_Addr  in  AW  channel A destination register
A_Data  in  DW  channel A result
A_Ready  out  1  channel A accepted this cycle if A_Valid
M_Valid  in  1  channel M result valid
M_Addr  in  AW  channel M destination register
M_Data  in  DW  channel M result
M_Ready  out  1  channel M accepted this cycle if M_Valid
Drain_En  in  1  permits draining this cycle; 0 = hold queue
Rd_Wen  out  1  write enable, register file port Rd
Rd_Addr  out  AW  port Rd address
Rd_Data  out  DW  port Rd data
Rs_Wen  out  1  write enable, register file port Rs
Rs_Addr  out  AW  port Rs address
Rs_Data  out  DW  port Rs data
Pend_Addr  in  AW  lookup address
Pend_Hit  out  1  1 if any queued entry targets Pend_Addr
Count  out  log2(DEPTH)+1  occupancy
Addr_Err  out  1  sticky: an illegal address was offered and dropped

Behaviour:
- Reset (async, Reset_n=0): Count=0, rd/wr pointers 0, all storage 0, Addr_Err=0; hence Rd_Wen=Rs_Wen=0, Rd/Rs addr and data 0, Pend_Hit=0, A_Ready=M_Ready=1 once deasserted. Reset mid-operation discards all queued entries; nothing further is written.
- Free slots F = DEPTH - Count (registered Count; same-cycle drains do not create space).
- A_Ready = (F >= 1). M_Ready = A_Valid ? (F >= 2) : (F >= 1). Ready does not depend on Drain_En.
- Enqueue order within a cycle: A before M. Accept = Valid && Ready.
- Accepted item with Addr >= NREG: not enqueued, Addr_Err set to 1 until reset; handshake still completes (Ready unchanged).
- Drain (combinational from registered FIFO head): Rd_Wen = Drain_En && Count>=1, Rd_* = oldest entry; Rs_Wen = Drain_En && Count>=2, Rs_* = second-oldest. Entries whose Wen is high are popped at the same rising edge the register file writes them.
- Same destination in both drained entries: both driven; register file gives Rs precedence, so the newer value lands. No special-casing.
- Latency: item accepted at edge N appears on Rd/Rs outputs after edge N, written into register file at edge N+1 (if Drain_En and head).
- Next Count = Count + enqueued - popped; simultaneous enqueue and dequeue legal at any occupancy, including full (pop does not raise Ready that cycle).
- Pointers wrap modulo DEPTH.
- Rd/Rs outputs when Wen=0 show head storage contents; don't-care for the register file.
- Pend_Hit: combinational OR over all valid entries of (entry addr == Pend_Addr); entries popping this cycle still count.
- Count never exceeds DEPTH; Ready logic guarantees no overflow.

Test Plan:
- Reset then A_Valid=1,A_Addr=3,A_Data=0x1234, Drain_En=1 -> next cycle Rd_Wen=1,Rd_Addr=3,Rd_Data=0x1234,Rs_Wen=0; following cycle Count=0, R3 reads 0x1234.
- Same cycle A(5,0xAAAA), M(5,0xBBBB), Drain_En=1 -> next cycle Rd=(5,0xAAAA),Rs=(5,0xBBBB), both Wen=1; R5 reads 0xBBBB afterward.
- Drain_En=0, offer A and M pairs each cycle -> Count 2,4; at Count=4 A_Ready=M_Ready=0; at Count=3 with both valid A_Ready=1,M_Ready=0.
- Full queue, Drain_En=1 for two cycles with no input -> entries emerge in enqueue order, two per cycle; Count 4->2->0; pointers wrap correctly on refill.
- A_Addr=20 accepted -> Addr_Err=1, Count unchanged, no write; Addr_Err held until Reset_n=0.
- Queue holding addr 7, Pend_Addr=7 -> Pend_Hit=1; after drain Pend_Hit=0; assert Reset_n=0 with 3 entries queued -> Count=0, no Wen.
